// File: rtl/vram_arbiter.sv
// Arbitrates a single-port VRAM between PPU fetches and CPU accesses.
// The PPU always wins during ACTIVE_PICTURE; a CPU access that collides with it is denied and counted.
module vram_arbiter #(
   parameter int          ADDR_W       = 13,
   parameter logic [7:0]  BLOCKED_DATA = 8'hFF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        ppu_mode,
   input  logic [ADDR_W-1:0] ppu_addr,
   output logic [7:0]        ppu_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_blocked,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        block_cnt
);

   // state   | meaning
   // IDLE    | PPU owns VRAM, waiting for a CPU request
   // RD_WAIT | CPU read address presented, VRAM read in flight
   // RD_CAP  | VRAM read data valid, captured into cpu_rdata
   // WR      | CPU write strobed into VRAM
   // BLOCK   | access denied by ACTIVE_PICTURE, denial counted
   // ACK     | one-cycle completion pulse to the CPU
   // REL     | waiting for the CPU to drop its request
   typedef enum logic [2:0] {
      S_IDLE, S_RD_WAIT, S_RD_CAP, S_WR, S_BLOCK, S_ACK, S_REL
   } state_t;

   localparam logic [1:0] MODE_ACTIVE = 2'd3;

   state_t     state_q, state_d;
   logic       blocked_q, blocked_d;
   logic [7:0] cpu_rdata_q, cpu_rdata_d;
   logic [7:0] block_cnt_q, block_cnt_d;
   logic       cpu_ack_q, cpu_ack_d;
   logic       cpu_blocked_q, cpu_blocked_d;
   logic       ppu_active;
   logic       cpu_owns_mem;

   assign ppu_active = (ppu_mode == MODE_ACTIVE);

   always_comb begin
      state_d     = state_q;
      blocked_d   = blocked_q;
      cpu_rdata_d = cpu_rdata_q;
      block_cnt_d = block_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               if (ppu_active) begin
                  state_d = S_BLOCK;
               end else if (cpu_we) begin
                  state_d   = S_WR;
                  blocked_d = 1'b0;
               end else begin
                  state_d   = S_RD_WAIT;
                  blocked_d = 1'b0;
               end
            end
         end
         S_RD_WAIT: state_d = ppu_active ? S_BLOCK : S_RD_CAP;
         S_RD_CAP: begin
            if (ppu_active) begin
               state_d = S_BLOCK;
            end else begin
               cpu_rdata_d = mem_rdata;
               state_d     = S_ACK;
            end
         end
         S_WR: state_d = ppu_active ? S_BLOCK : S_ACK;
         S_BLOCK: begin
            if (!cpu_we) cpu_rdata_d = BLOCKED_DATA;
            if (block_cnt_q != 8'hFF) block_cnt_d = block_cnt_q + 8'd1;
            blocked_d = 1'b1;
            state_d   = S_ACK;
         end
         S_ACK: state_d = S_REL;
         S_REL: if (!cpu_req) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      cpu_ack_d     = (state_d == S_ACK);
      cpu_blocked_d = (state_d == S_ACK) && blocked_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         blocked_q     <= 1'b0;
         cpu_rdata_q   <= 8'h00;
         block_cnt_q   <= 8'h00;
         cpu_ack_q     <= 1'b0;
         cpu_blocked_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         blocked_q     <= blocked_d;
         cpu_rdata_q   <= cpu_rdata_d;
         block_cnt_q   <= block_cnt_d;
         cpu_ack_q     <= cpu_ack_d;
         cpu_blocked_q <= cpu_blocked_d;
      end
   end

   // The memory port follows ppu_mode combinationally so a preempted write never strobes.
   assign cpu_owns_mem = !ppu_active &&
                         (state_q == S_RD_WAIT || state_q == S_RD_CAP || state_q == S_WR);

   assign mem_addr    = cpu_owns_mem ? cpu_addr : ppu_addr;
   assign mem_we      = (state_q == S_WR) && !ppu_active;
   assign mem_wdata   = cpu_wdata;
   assign ppu_data    = mem_rdata;
   assign cpu_rdata   = cpu_rdata_q;
   assign cpu_ack     = cpu_ack_q;
   assign cpu_blocked = cpu_blocked_q;
   assign block_cnt   = block_cnt_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, VRAM byte-address width (8 KB).
REQ-002 SHALL have parameter BLOCKED_DATA, default 8'hFF, read data returned to a denied CPU read.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ppu_mode  input  2  PPU mode: 0 HBLANK, 1 VBLANK, 2 OAM_SEARCH, 3 ACTIVE_PICTURE.
REQ-006 SHALL have port ppu_addr  input  ADDR_W  PPU fetch address.
REQ-007 SHALL have port ppu_data  output  8  PPU read data, equal to mem_rdata.
REQ-008 SHALL have port cpu_req  input  1  CPU request; level, held until cpu_ack.
REQ-009 SHALL have port cpu_we  input  1  1 = write, 0 = read; stable while cpu_req high.
REQ-010 SHALL have port cpu_addr  input  ADDR_W  CPU address; stable while cpu_req high.
REQ-011 SHALL have port cpu_wdata  input  8  CPU write data.
REQ-012 SHALL have port cpu_rdata  output  8  registered CPU read data.
REQ-013 SHALL have port cpu_ack  output  1  one-cycle completion pulse.
REQ-014 SHALL have port cpu_blocked  output  1  high with cpu_ack when the access was denied.
REQ-015 SHALL have port mem_addr  output  ADDR_W  single-port VRAM address.
REQ-016 SHALL have port mem_wdata  output  8  VRAM write data, equal to cpu_wdata.
REQ-017 SHALL have port mem_we  output  1  VRAM write enable.
REQ-018 SHALL have port mem_rdata  input  8  synchronous VRAM read data, valid one cycle after mem_addr.
REQ-019 SHALL have port block_cnt  output  8  saturating count of denied CPU accesses.

Function
REQ-020 The block SHALL implement states IDLE, RD_WAIT, RD_CAP, WR, BLOCK, ACK and REL.
REQ-021 From IDLE with cpu_req=1: ppu_mode==3 -> BLOCK; else cpu_we=1 -> WR; else -> RD_WAIT. With cpu_req=0 it SHALL stay in IDLE.
REQ-022 RD_WAIT: mem_addr=cpu_addr; next state RD_CAP.
REQ-023 RD_CAP: mem_addr=cpu_addr; cpu_rdata<=mem_rdata; next state ACK.
REQ-024 WR: mem_addr=cpu_addr, mem_we=1 for exactly this cycle; next state ACK.
REQ-025 BLOCK: cpu_rdata<=BLOCKED_DATA on reads (unchanged on writes); block_cnt increments unless it is 8'hFF; next state ACK with the blocked flag set.
REQ-026 ACK: cpu_ack=1 and cpu_blocked=blocked flag for one cycle; next state REL.
REQ-027 REL: stay until cpu_req=0, then go to IDLE; a held request SHALL NOT be serviced twice.
REQ-028 Preemption: ppu_mode==3 in RD_WAIT, RD_CAP or WR SHALL abort to BLOCK; mem_we SHALL be 0 in that cycle and cpu_rdata SHALL NOT take mem_rdata.
REQ-029 mem_addr SHALL equal ppu_addr whenever ppu_mode==3 or the state is IDLE, BLOCK, ACK or REL.
REQ-030 mem_we SHALL be 1 only in WR with ppu_mode!=3.
REQ-031 ppu_data SHALL be combinationally equal to mem_rdata in every state.
REQ-032 Uncontended CPU latency, request to cpu_ack: read 3 cycles, write 2 cycles, blocked 2 cycles.
REQ-033 The blocked flag SHALL clear on entry to RD_WAIT or WR.

Reset
REQ-034 reset_n=0 SHALL immediately force state IDLE, cpu_ack=0, cpu_blocked=0, mem_we=0, cpu_rdata=8'h00, block_cnt=8'h00 and blocked flag=0.
REQ-035 Reset asserted mid-transaction SHALL abandon it with no write, and SHALL NOT produce an ack after release.

Verification
REQ-036 ppu_mode=0, read 0x1800 holding 0x5A -> cpu_ack on cycle 3, cpu_rdata=0x5A, cpu_blocked=0.
REQ-037 ppu_mode=1, write 0x0010=0x3C -> mem_we=1 for one cycle with addr 0x0010, ack on cycle 2; a later read returns 0x3C.
REQ-038 ppu_mode=3, read -> ack on cycle 2, cpu_rdata=0xFF, cpu_blocked=1, block_cnt 0->1, mem_addr tracks ppu_addr throughout.
REQ-039 Write issued in mode 2 with mode switching to 3 in the WR cycle -> mem_we stays 0, ack with cpu_blocked=1, VRAM unchanged.
REQ-040 cpu_req held high 5 cycles after ack -> exactly one ack; 256 blocked accesses -> block_cnt saturates at 0xFF.
REQ-041 reset_n pulsed low during RD_CAP -> all outputs take their reset values asynchronously, no ack follows, block_cnt=0.
